// File: rtl/reqser_pkg.sv
// rtl/reqser_pkg.sv - shared types and helpers for the request-vector serializer
package reqser_pkg;

    // Controller states: waiting for a vector, or emitting its indices.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Smallest index width able to address 'width' request lines (minimum 1).
    function automatic int idx_width(input int width);
        int w;
        w = 1;
        while ((1 << w) < width) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lsb_idx.sv
// rtl/lsb_idx.sv - combinational lowest-set-bit to binary index encoder
module lsb_idx
    import reqser_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDXW = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o
);

    // Scan from the top down so the lowest set bit is the last to win; all-zero yields 0.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/req_serializer.sv
// rtl/req_serializer.sv - serializes a multi-hot request vector into binary indices, lowest first (optional out_last via REQSER_LAST_EN)
module req_serializer
    import reqser_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDXW = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef REQSER_LAST_EN
    ,
    output logic             out_last
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] pending_clr;
    logic [IDXW-1:0]  lsb_pos;

    lsb_idx #(
        .WIDTH (WIDTH)
    ) u_lsb_idx (
        .vec_i (pending_q),
        .idx_o (lsb_pos)
    );

    // Pending vector with its lowest set bit removed; zero means the current beat is the last.
    assign pending_clr = pending_q & (pending_q - WIDTH'(1));

    // State and pending registers; reset discards any partially drained vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic: load non-zero vectors in IDLE, retire one bit per output handshake in DRAIN.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                // A zero vector is accepted and silently dropped.
                if (in_valid && (in_vec != '0)) begin
                    pending_d = in_vec;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs come from the state register only, forced low while reset is asserted.
    always_comb begin
        in_ready  = rst && (state_q == IDLE);
        out_valid = rst && (state_q == DRAIN);
        busy      = out_valid;
        out_idx   = out_valid ? lsb_pos : '0;
    end

`ifdef REQSER_LAST_EN
    // Last beat is flagged when only one pending bit remains.
    always_comb begin
        out_last = out_valid && (pending_clr == '0);
    end
`endif

endmodule

// File: tb/tb_req_serializer.sv
// tb/tb_req_serializer.sv - self-checking bench for req_serializer against a queue-based reference model
module tb_req_serializer;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef REQSER_LAST_EN
    logic             out_last;
`endif

    int n_checks;
    int n_fail;

    req_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef REQSER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".out_idx"}, 32'(out_idx), 32'd0);
    endtask

    // Offer one vector, then consume every beat and compare against the set-bit list.
    // stall: cycles of out_ready=0 before the first beat is taken; rnd: random out_ready afterwards.
    task automatic send(input string tag, input logic [WIDTH-1:0] vec, input int stall, input bit rnd);
        int exp_q[$];
        int cyc;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) exp_q.push_back(i);
        end
        chk({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        in_vec    = vec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = $urandom_range(0, 255);
        cyc = 0;
        while (exp_q.size() != 0) begin
            if (cyc > 200) begin
                chk({tag, ".timeout"}, 32'd1, 32'd0);
                exp_q.delete();
                break;
            end
            if (cyc < stall) out_ready = 1'b0;
            else if (rnd)    out_ready = ($urandom_range(0, 3) != 0);
            else             out_ready = 1'b1;
            chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".out_idx"}, 32'(out_idx), 32'(exp_q[0]));
`ifdef REQSER_LAST_EN
            chk({tag, ".out_last"}, 32'(out_last), 32'(exp_q.size() == 1));
`endif
            @(negedge clk);
            if (out_ready) void'(exp_q.pop_front());
            cyc++;
        end
        out_ready = 1'b0;
        chk_idle({tag, ".done"});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 8'h5A;
        out_ready = 1'b1;

        // Reset held for 3 cycles with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.in_ready", 32'(in_ready), 32'd0);
            chk("rst.out_valid", 32'(out_valid), 32'd0);
            chk("rst.busy", 32'(busy), 32'd0);
            chk("rst.out_idx", 32'(out_idx), 32'd0);
`ifdef REQSER_LAST_EN
            chk("rst.out_last", 32'(out_last), 32'd0);
`endif
        end
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");

        // Straight drain of A4: beats 2, 5, 7 back to back.
        send("drain_a4", 8'hA4, 0, 1'b0);
        // Backpressure for 3 cycles on the first beat.
        send("bp_a4", 8'hA4, 3, 1'b0);

        // Zero vector: accepted, nothing emitted.
        in_vec   = 8'h00;
        in_valid = 1'b1;
        chk("zero.accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_idle("zero.next");
        @(negedge clk);
        chk_idle("zero.next2");

        // Reset right after beat idx=2.
        in_vec   = 8'hA4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mrst.beat0", 32'(out_idx), 32'd2);
        chk("mrst.beat0_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("mrst.after");
        end
        out_ready = 1'b0;

        // Single-bit and adjacent-bit vectors (last-beat flagging).
        send("single_80", 8'h80, 0, 1'b0);
        send("pair_03", 8'h03, 0, 1'b0);
        send("all_ff", 8'hFF, 2, 1'b0);

        // Randomized vectors with random consumer stalls.
        for (int t = 0; t < 40; t++) begin
            logic [WIDTH-1:0] v;
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : WIDTH'($urandom_range(0, 255));
            send($sformatf("rand%0d", t), v, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
